// File: rtl/fifo_rd_stream.sv
// Read-side consumer of async_fifo: pops FWFT words into a 2-entry skid buffer
// and presents them as a valid/ready stream with packet framing and a packet counter.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);

  logic [1:0]            occ_q,  occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [7:0]            beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  pkt_q,  pkt_d;

  logic push;
  logic pop;

  // rinc is a function of registered occupancy and the FIFO/flush inputs only,
  // so out_ready never reaches the FIFO pop combinationally.
  assign rinc      = !rrst && !rempty && !flush && (occ_q != 2'd2);
  assign push      = rinc;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head_q;
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign pkt_cnt   = pkt_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    pkt_d  = pkt_q;

    // A beat accepted alongside a flush is still delivered and counted.
    if (pop) begin
      if (out_last) begin
        beat_d = '0;
        pkt_d  = pkt_q + CNT_WIDTH'(1);
      end else begin
        beat_d = beat_q + 8'd1;
      end
    end

    if (flush) begin
      occ_d  = '0;
      beat_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = rdata;
            occ_d  = 2'd1;
          end else begin
            tail_d = rdata;
            occ_d  = 2'd2;
          end
        end
        2'b01: begin
          if (occ_q == 2'd2) head_d = tail_q;
          occ_d = occ_q - 2'd1;
        end
        // push implies occ<2 and pop implies occ>0, so occ is 1 here
        2'b11: head_d = rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      beat_q <= '0;
      pkt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      beat_q <= beat_d;
      pkt_q  <= pkt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and random bench for fifo_rd_stream, fed by a behavioural FWFT FIFO.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] pkt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [256];
  logic [7:0] wp = '0;
  logic [7:0] rp = '0;
  logic       fifo_clr = 1'b0;

  assign rempty = (wp == rp);
  assign rdata  = mem[rp];

  always @(posedge rclk) begin
    if (fifo_clr)  rp <= wp;
    else if (rinc) rp <= rp + 8'd1;
  end

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .pkt_cnt(pkt_cnt)
  );

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 8'd1;
  endtask

  // Holds the DUT in reset and empties the model FIFO.
  task automatic clear();
    rrst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
  endtask

  task automatic load8();
    for (int unsigned i = 1; i <= 8; i++) push(8'(i));
  endtask

  task automatic release_rst();
    rrst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear();
    push(8'hA5);
    #1;
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL reset_rinc got=%b exp=0", rinc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
    n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pkt got=%0d exp=0", pkt_cnt); end
    release_rst();
    n_cmp++; if (rinc !== 1'b1) begin n_bad++; $display("FAIL reset_release_rinc got=%b exp=1", rinc); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_bad++; $display("FAIL reset_first_word got=%b/%h exp=1/a5", out_valid, out_data);
    end
  endtask

  task automatic test_streaming();
    clear();
    load8();
    out_ready = 1'b1;
    release_rst();
    n_cmp++; if (rinc !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stream_start rinc/valid got=%b/%b exp=1/0", rinc, out_valid);
    end
    for (int unsigned k = 1; k <= 8; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        n_bad++; $display("FAIL stream_data beat=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 8'(k));
      end
      n_cmp++; if (out_last !== (k % 4 == 0)) begin
        n_bad++; $display("FAIL stream_last beat=%0d got=%b exp=%b", k, out_last, (k % 4 == 0));
      end
      n_cmp++; if (rinc !== (k < 8)) begin
        n_bad++; $display("FAIL stream_rinc beat=%0d got=%b exp=%b", k, rinc, (k < 8));
      end
    end
    step();
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== 16'd2) begin
      n_bad++; $display("FAIL stream_end valid/pkt got=%b/%0d exp=0/2", out_valid, pkt_cnt);
    end
  endtask

  task automatic test_backpressure();
    int rinc_hi;
    rinc_hi = 0;
    clear();
    load8();
    release_rst();
    for (int unsigned c = 0; c < 5; c++) begin
      if (rinc === 1'b1) rinc_hi++;
      if (c > 0) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_last !== 1'b0) begin
          n_bad++; $display("FAIL bp_hold cycle=%0d got=%b/%h/%b exp=1/01/0", c, out_valid, out_data, out_last);
        end
      end
      step();
    end
    n_cmp++; if (rinc_hi !== 2 || rinc !== 1'b0) begin
      n_bad++; $display("FAIL bp_rinc_count got=%0d/%b exp=2/0", rinc_hi, rinc);
    end
    out_ready = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        n_bad++; $display("FAIL bp_drain beat=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 8'(k));
      end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== 16'd2) begin
      n_bad++; $display("FAIL bp_end valid/pkt got=%b/%0d exp=0/2", out_valid, pkt_cnt);
    end
  endtask

  task automatic test_flush();
    clear();
    load8();
    out_ready = 1'b1;
    release_rst();
    step();
    step();
    step();
    out_ready = 1'b0;
    step();
    n_cmp++; if (out_data !== 8'h03 || rinc !== 1'b0) begin
      n_bad++; $display("FAIL flush_pre data/rinc got=%h/%b exp=03/0", out_data, rinc);
    end
    flush = 1'b1;
    #1;
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL flush_rinc got=%b exp=0", rinc); end
    step();
    flush = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || pkt_cnt !== 16'd0) begin
      n_bad++; $display("FAIL flush_post valid/pkt got=%b/%0d exp=0/0", out_valid, pkt_cnt);
    end
    out_ready = 1'b1;
    step();
    for (int unsigned k = 0; k < 4; k++) begin
      n_cmp++; if (out_data !== 8'(5 + k) || out_last !== (k == 3)) begin
        n_bad++; $display("FAIL flush_reframe beat=%0d got=%h/%b exp=%h/%b", k, out_data, out_last, 8'(5 + k), (k == 3));
      end
      step();
    end
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL flush_pkt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_flush_on_last();
    clear();
    load8();
    out_ready = 1'b1;
    release_rst();
    for (int unsigned k = 0; k < 4; k++) step();
    n_cmp++; if (out_last !== 1'b1 || out_data !== 8'h04) begin
      n_bad++; $display("FAIL fol_last got=%b/%h exp=1/04", out_last, out_data);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_cmp++; if (pkt_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL fol_pkt pkt/valid got=%0d/%b exp=1/0", pkt_cnt, out_valid);
    end
  endtask

  task automatic test_async_reset();
    clear();
    load8();
    release_rst();
    step();
    step();
    n_cmp++; if (out_valid !== 1'b1 || rinc !== 1'b0) begin
      n_bad++; $display("FAIL arst_pre valid/rinc got=%b/%b exp=1/0", out_valid, rinc);
    end
    #2;
    rrst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || rinc !== 1'b0 || out_data !== 8'h00) begin
      n_bad++; $display("FAIL arst_now valid/rinc/data got=%b/%b/%h exp=0/0/00", out_valid, rinc, out_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [200];
    int         sent, got, cyc, bad_order, bad_hold;
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_last;
    sent = 0; got = 0; cyc = 0; bad_order = 0; bad_hold = 0;
    prev_stall = 1'b0; prev_d = '0; prev_last = 1'b0;
    for (int i = 0; i < 200; i++) exp_q[i] = 8'($urandom);
    clear();
    release_rst();
    while (got < 200 && cyc < 5000) begin
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_last) begin
          n_bad++; bad_hold++;
          if (bad_hold < 5) $display("FAIL rand_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, out_valid, out_data, out_last, prev_d, prev_last);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 200 && $urandom_range(0, 2) != 0) begin
        push(exp_q[sent]);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== exp_q[got]) begin
          n_bad++; bad_order++;
          if (bad_order < 5) $display("FAIL rand_order idx=%0d got=%h exp=%h", got, out_data, exp_q[got]);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_last  = out_last;
      step();
      cyc++;
    end
    n_cmp++; if (got !== 200) begin n_bad++; $display("FAIL rand_timeout got=%0d exp=200", got); end
    n_cmp++; if (pkt_cnt !== 16'd50) begin n_bad++; $display("FAIL rand_pkt got=%0d exp=50", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_on_last();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer of async_fifo, in the rclk domain. Pops words through the FIFO's rinc/rdata/rempty interface and presents them as a registered valid/ready stream. Holds up to two words internally so the stream runs at full throughput with no combinational path from out_ready to rinc. Marks packet boundaries with out_last every PKT_LEN beats and counts completed packets.

Parameters:
DATA_WIDTH, 8, width of FIFO words and out_data.
PKT_LEN, 4, beats per packet; legal range 1..256.
CNT_WIDTH, 16, width of the pkt_cnt output.

Ports:
rclk  input  1  read-domain clock; all logic on the rising edge.
rrst  input  1  asynchronous, active-high reset.
rdata  input  DATA_WIDTH  FIFO read data; valid whenever rempty=0 (first-word fall-through).
rempty  input  1  FIFO empty flag.
rinc  output  1  FIFO pop strobe; pops rdata on this rising edge.
flush  input  1  synchronous; discards buffered words and restarts packet framing.
out_valid  output  1  stream data valid.
out_ready  input  1  downstream accept.
out_data  output  DATA_WIDTH  stream data.
out_last  output  1  final beat of a packet; qualified by out_valid.
pkt_cnt  output  CNT_WIDTH  count of completed packets; wraps.

Behaviour:
- Storage: 2-entry buffer (head/tail registers) with occupancy occ in 0..2. out_valid = (occ != 0). out_data = head. Data is never modified in place.
- Reset (rrst=1, async): occ=0, head=tail=0, beat_cnt=0, pkt_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, out_last=0 (PKT_LEN=1 included, because out_valid=0), pkt_cnt=0.
  - rinc is forced to 0 while rrst=1.
  - Reset mid-transfer discards buffered words. Words already popped are lost; this is accepted.
- Pop rule: rinc = !rrst && !rempty && !flush && (occ != 2). rinc depends only on registered state and FIFO flags.
- Push on a rinc edge: rdata is written to head if occ=0, or if occ=1 and a pop-out also occurs that edge. Otherwise it is written to tail.
- Pop-out (out_valid && out_ready): tail moves to head if occ=2.
- Simultaneous push and pop-out: occ is unchanged.
- Latency: rempty falls in cycle N → rinc=1 in cycle N → out_valid=1 in cycle N+1 with that word. Minimum latency 1 rclk.
- Throughput: sustained 1 word/cycle when the FIFO is non-empty and out_ready=1 (occ stays at 1).
- Backpressure:
  - With out_ready=0, the buffer fills to 2 and rinc then drops.
  - out_data, out_valid and out_last hold stable until accepted.
- Packet framing:
  - beat_cnt (8 bits) counts accepted beats. out_last = out_valid && (beat_cnt == PKT_LEN-1).
  - On accepting a beat with out_last=1: beat_cnt ← 0 and pkt_cnt ← pkt_cnt+1 (mod 2^CNT_WIDTH). Otherwise an accepted beat increments beat_cnt.
  - PKT_LEN=1: every valid beat is last.
- Flush (flush=1 at an edge): occ ← 0 and beat_cnt ← 0; pkt_cnt is unchanged.
  - rinc=0 that cycle, so no FIFO word is lost by the flush itself.
  - A handshake in the same cycle as flush is still counted into pkt_cnt if it was a last beat. Its data is considered delivered.
- rempty rising during buffering has no effect beyond rinc=0. There are no underflow or overflow paths: push only when occ<2, pop-out only when occ>0.

Test Plan:
- Reset: hold rrst=1 with rempty=0 → rinc=0, out_valid=0, out_data=0, pkt_cnt=0. Release rrst → rinc=1 in the next cycle.
- Streaming: FIFO preloaded with 0x01..0x08, PKT_LEN=4, out_ready=1 →
  - out_data 0x01..0x08 on consecutive cycles, first one cycle after rinc.
  - out_last on 0x04 and 0x08; pkt_cnt=2; rinc never drops while rempty=0.
- Backpressure: 8 words queued, out_ready=0 for 5 cycles →
  - rinc high for exactly 2 cycles; out_data=0x01 held; occ=2.
  - Then out_ready=1 → 0x01..0x08 in order with no gaps.
- Flush: PKT_LEN=4, after 2 accepted beats with occ=2, pulse flush →
  - out_valid=0 next cycle; rinc=0 during the flush cycle.
  - Next accepted words restart framing: out_last on the 4th beat after flush; pkt_cnt unchanged.
- Random cross-clock: async_fifo (wclk 20 ns, rclk 70 ns) feeding this block, random out_ready, 200 random words →
  - Output order equals write order; pkt_cnt = 200/PKT_LEN = 50.
  - Assertion: out_data and out_last stable while out_valid && !out_ready.
- Mid-run reset: assert rrst asynchronously between edges with occ=2 → out_valid=0 and rinc=0 immediately, before the next rclk edge.
